regfile_dual: RTL

Dual-write, quad-read general register file with HI/LO registers, sitting at the receiving end of the WB stage's `wb_to_rf_bus`. Commits both issue slots' GPR and HI/LO results in one clock, resolves same-cycle conflicts in program order (slot i2 younger, wins), and serves ID's four GPR read ports plus HI/LO reads with write-through bypass.

---
 rtl/regfile_dual_pkg.sv | 21 ++
 rtl/rf_bypass_mux.sv | 22 ++
 rtl/regfile_dual.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_dual_pkg.sv
// regfile_dual_pkg: shared widths, reset value and WB commit bus layout for the register file.
package regfile_dual_pkg;
    localparam int GPR_WD        = 32;
    localparam int HILO_WD_P     = 2 + 2 * GPR_WD;
    localparam int WB_TO_RF_WD_P = 2 * (HILO_WD_P + 1 + 5 + GPR_WD);
    localparam logic [GPR_WD-1:0] RESET_WORD = '0;

    typedef struct packed {
        logic              hi_we;
        logic              lo_we;
        logic [GPR_WD-1:0] hi_wdata;
        logic [GPR_WD-1:0] lo_wdata;
    } hilo_bus_t;

    typedef struct packed {
        hilo_bus_t         hilo;
        logic              we;
        logic [4:0]        waddr;
        logic [GPR_WD-1:0] wdata;
    } wb_slot_t;
endpackage

// File: rtl/rf_bypass_mux.sv
// rf_bypass_mux: read one register with write-through bypass, younger slot i2 over i1 over stored.
module rf_bypass_mux
    import regfile_dual_pkg::*;
(
    input  logic [4:0]        i_raddr,
    input  logic              i_we2,
    input  logic [4:0]        i_waddr2,
    input  logic [GPR_WD-1:0] i_wdata2,
    input  logic              i_we1,
    input  logic [4:0]        i_waddr1,
    input  logic [GPR_WD-1:0] i_wdata1,
    input  logic [GPR_WD-1:0] i_stored,
    output logic [GPR_WD-1:0] o_rdata
);
    logic w_hit2, w_hit1;

    assign w_hit2  = i_we2 && (i_waddr2 == i_raddr);
    assign w_hit1  = i_we1 && (i_waddr1 == i_raddr);
    assign o_rdata = (i_raddr == 5'd0) ? RESET_WORD :
                     w_hit2            ? i_wdata2   :
                     w_hit1            ? i_wdata1   : i_stored;
endmodule

// File: rtl/regfile_dual.sv
// regfile_dual: dual-commit, quad-read GPR file with HI/LO and same-cycle write-through bypass.
module regfile_dual
    import regfile_dual_pkg::*;
#(
    parameter int WB_TO_RF_WD = WB_TO_RF_WD_P,
    parameter int HILO_WD     = HILO_WD_P
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [4:0]             raddr1_i1,
    input  logic [4:0]             raddr2_i1,
    input  logic [4:0]             raddr1_i2,
    input  logic [4:0]             raddr2_i2,
    output logic [GPR_WD-1:0]      rdata1_i1,
    output logic [GPR_WD-1:0]      rdata2_i1,
    output logic [GPR_WD-1:0]      rdata1_i2,
    output logic [GPR_WD-1:0]      rdata2_i2,
    output logic [GPR_WD-1:0]      hi_rdata,
    output logic [GPR_WD-1:0]      lo_rdata
);
    localparam int SLOT_WD = HILO_WD + 1 + 5 + GPR_WD;

    wb_slot_t          w_s1, w_s2;
    logic [GPR_WD-1:0] r_gpr [1:31];
    logic [GPR_WD-1:0] r_hi, r_lo;
    logic [4:0]        w_raddr [4];
    logic [GPR_WD-1:0] w_rdata [4];

    assign w_s1 = wb_slot_t'(wb_to_rf_bus[SLOT_WD-1:0]);
    assign w_s2 = wb_slot_t'(wb_to_rf_bus[2*SLOT_WD-1 -: SLOT_WD]);

    // i2 is the younger instruction, so its writes are issued last and win on a shared target
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 1; i < 32; i++) r_gpr[i] <= RESET_WORD;
            r_hi <= RESET_WORD;
            r_lo <= RESET_WORD;
        end else begin
            if (w_s1.we && w_s1.waddr != 5'd0) r_gpr[w_s1.waddr] <= w_s1.wdata;
            if (w_s2.we && w_s2.waddr != 5'd0) r_gpr[w_s2.waddr] <= w_s2.wdata;
            if (w_s2.hilo.hi_we)      r_hi <= w_s2.hilo.hi_wdata;
            else if (w_s1.hilo.hi_we) r_hi <= w_s1.hilo.hi_wdata;
            if (w_s2.hilo.lo_we)      r_lo <= w_s2.hilo.lo_wdata;
            else if (w_s1.hilo.lo_we) r_lo <= w_s1.hilo.lo_wdata;
        end
    end

    assign w_raddr   = '{raddr1_i1, raddr2_i1, raddr1_i2, raddr2_i2};
    assign rdata1_i1 = w_rdata[0];
    assign rdata2_i1 = w_rdata[1];
    assign rdata1_i2 = w_rdata[2];
    assign rdata2_i2 = w_rdata[3];

    for (genvar k = 0; k < 4; k++) begin : g_rd
        logic [GPR_WD-1:0] w_stored;
        assign w_stored = (w_raddr[k] == 5'd0) ? RESET_WORD : r_gpr[w_raddr[k]];
        rf_bypass_mux u_mux (
            .i_raddr (w_raddr[k]),
            .i_we2   (w_s2.we),
            .i_waddr2(w_s2.waddr),
            .i_wdata2(w_s2.wdata),
            .i_we1   (w_s1.we),
            .i_waddr1(w_s1.waddr),
            .i_wdata1(w_s1.wdata),
            .i_stored(w_stored),
            .o_rdata (w_rdata[k])
        );
    end

    // HI/LO have no address: matching constant addresses make every enabled write a hit
    rf_bypass_mux u_hi (
        .i_raddr (5'd1),
        .i_we2   (w_s2.hilo.hi_we),
        .i_waddr2(5'd1),
        .i_wdata2(w_s2.hilo.hi_wdata),
        .i_we1   (w_s1.hilo.hi_we),
        .i_waddr1(5'd1),
        .i_wdata1(w_s1.hilo.hi_wdata),
        .i_stored(r_hi),
        .o_rdata (hi_rdata)
    );

    rf_bypass_mux u_lo (
        .i_raddr (5'd1),
        .i_we2   (w_s2.hilo.lo_we),
        .i_waddr2(5'd1),
        .i_wdata2(w_s2.hilo.lo_wdata),
        .i_we1   (w_s1.hilo.lo_we),
        .i_waddr1(5'd1),
        .i_wdata1(w_s1.hilo.lo_wdata),
        .i_stored(r_lo),
        .o_rdata (lo_rdata)
    );
endmodule
